// File: rtl/jtframe_ram_upload.sv
// jtframe_ram_upload
// Reads an SDRAM region word by word over the prog_* port and serves it byte-wise
// to the SPI io controller while it uploads RAM to SD (ioctl_ram=1).
// Ports:
//   clk_rom, rst               clock, asynchronous active-high reset
//   ioctl_ram                  upload session active (level)
//   ioctl_addr, ioctl_rd       requested byte address, byte-consumed strobe
//   ioctl_data2sd              byte served for ioctl_addr (8'hFF outside region/session)
//   up_busy, up_ovr            current word not ready / sticky consumer overrun
//   prog_addr, prog_ba,        SDRAM read request port (request held until prog_ack)
//   prog_rd, prog_ack,
//   prog_rdy, sdram_dout       SDRAM read data return
module jtframe_ram_upload #(
  parameter int unsigned        SDRAMW = 23,
  parameter logic [SDRAMW-1:0]  UPBASE = '0,
  parameter logic [1:0]         UPBA   = 2'd0,
  parameter logic [31:0]        UPSIZE = 32'h2000,
  parameter logic               SWAB   = 1'b0
)(
  input  logic              clk_rom,
  input  logic              rst,
  input  logic              ioctl_ram,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_data2sd,
  output logic              up_busy,
  output logic              up_ovr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [1:0]        prog_ba,
  output logic              prog_rd,
  input  logic              prog_ack,
  input  logic              prog_rdy,
  input  logic [15:0]       sdram_dout
);

  localparam int unsigned CW = 64;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t             state_q, state_nx;
  logic               ram_l, discard, discard_nx;
  logic [SDRAMW-1:0]  fptr, fptr_nx;
  logic [15:0]        cur_q, nxt_q, cur_nx, nxt_nx;
  logic               cur_v, nxt_v, cur_v_nx, nxt_v_nx;
  logic               prog_rd_nx, up_ovr_nx, up_busy_nx;
  logic [SDRAMW-1:0]  prog_addr_nx;
  logic [7:0]         data_nx;
  logic               start, in_range, busy_c, shift, ovr_set, got, store, more, room;

  // Session/consumer event decode
  always_comb begin
    start    = ioctl_ram & ~ram_l;
    in_range = {7'd0, ioctl_addr} < UPSIZE;
    busy_c   = ioctl_ram & ~cur_v & in_range;
    shift    = ioctl_ram & ioctl_rd & ~busy_c & ioctl_addr[0];
    ovr_set  = ioctl_ram & ioctl_rd & busy_c;
    got      = (state_q == WAIT) & prog_rdy;
    // data returned for a request issued before the current session is dropped
    store    = got & ioctl_ram & ~discard & ~start;
    more     = {{(CW-1-SDRAMW){1'b0}}, fptr, 1'b0} < CW'(UPSIZE);
    room     = ~cur_v | ~nxt_v;
  end

  // State register
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (ioctl_ram && (start || (room && more))) state_nx = REQ;
      REQ:     if (prog_ack) state_nx = WAIT;
      WAIT:    if (prog_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs; the address is captured on entry to REQ and held there
  always_comb begin
    prog_rd_nx   = 1'b0;
    prog_addr_nx = prog_addr;
    if (state_nx == REQ) begin
      prog_rd_nx = 1'b1;
      if (state_q != REQ)
        prog_addr_nx = UPBASE + (start ? {SDRAMW{1'b0}} : fptr);
    end
  end

  // Two-word buffer: a shift frees NXT first, so a coincident return lands in the free slot
  always_comb begin
    cur_nx   = cur_q;
    nxt_nx   = nxt_q;
    cur_v_nx = cur_v;
    nxt_v_nx = nxt_v;
    if (!ioctl_ram || start) begin
      cur_v_nx = 1'b0;
      nxt_v_nx = 1'b0;
    end else begin
      if (shift) begin
        cur_nx   = nxt_q;
        cur_v_nx = nxt_v;
        nxt_v_nx = 1'b0;
      end
      if (store) begin
        if (!cur_v_nx) begin
          cur_nx   = sdram_dout;
          cur_v_nx = 1'b1;
        end else begin
          nxt_nx   = sdram_dout;
          nxt_v_nx = 1'b1;
        end
      end
    end
    fptr_nx = start ? {SDRAMW{1'b0}} : (store ? fptr + SDRAMW'(1) : fptr);
    up_ovr_nx = start ? 1'b0 : (up_ovr | ovr_set);
    if (state_q == IDLE || got) discard_nx = 1'b0;
    else                        discard_nx = discard | ~ioctl_ram | start;
    up_busy_nx = ioctl_ram & ~cur_v_nx & in_range;
    if (!ioctl_ram || !in_range) data_nx = 8'hFF;
    else if (ioctl_addr[0] ^ SWAB) data_nx = cur_q[15:8];
    else                           data_nx = cur_q[7:0];
  end

  // Datapath and output registers
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      ram_l         <= 1'b0;
      discard       <= 1'b0;
      fptr          <= '0;
      cur_q         <= '0;
      nxt_q         <= '0;
      cur_v         <= 1'b0;
      nxt_v         <= 1'b0;
      prog_rd       <= 1'b0;
      prog_addr     <= '0;
      prog_ba       <= 2'd0;
      up_ovr        <= 1'b0;
      up_busy       <= 1'b0;
      ioctl_data2sd <= 8'hFF;
    end else begin
      ram_l         <= ioctl_ram;
      discard       <= discard_nx;
      fptr          <= fptr_nx;
      cur_q         <= cur_nx;
      nxt_q         <= nxt_nx;
      cur_v         <= cur_v_nx;
      nxt_v         <= nxt_v_nx;
      prog_rd       <= prog_rd_nx;
      prog_addr     <= prog_addr_nx;
      prog_ba       <= UPBA;
      up_ovr        <= up_ovr_nx;
      up_busy       <= up_busy_nx;
      ioctl_data2sd <= data_nx;
    end
  end

endmodule

// File: tb/tb_jtframe_ram_upload.sv
// Bench for jtframe_ram_upload: two instances (A: SWAB=0, 64-byte region; B: SWAB=1,
// 4-byte region at the top of SDRAM to exercise address wrap) with an SDRAM responder.
module tb_jtframe_ram_upload;

  localparam logic [22:0] BASE_A = 23'h000100;
  localparam logic [22:0] BASE_B = 23'h7FFFFF;
  localparam logic [31:0] SIZE_A = 32'h40;
  localparam logic [31:0] SIZE_B = 32'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ioctl_ram [2];
  logic        ioctl_rd  [2];
  logic [24:0] ioctl_addr[2];
  logic [7:0]  data2sd   [2];
  logic        up_busy   [2];
  logic        up_ovr    [2];
  logic [22:0] prog_addr [2];
  logic [1:0]  prog_ba   [2];
  logic        prog_rd   [2];
  logic        prog_ack  [2];
  logic        prog_rdy  [2];
  logic [15:0] sdram_dout[2];

  jtframe_ram_upload #(.SDRAMW(23), .UPBASE(BASE_A), .UPBA(2'd0), .UPSIZE(SIZE_A), .SWAB(1'b0)) u_a (
    .clk_rom(clk), .rst(rst), .ioctl_ram(ioctl_ram[0]), .ioctl_addr(ioctl_addr[0]),
    .ioctl_rd(ioctl_rd[0]), .ioctl_data2sd(data2sd[0]), .up_busy(up_busy[0]), .up_ovr(up_ovr[0]),
    .prog_addr(prog_addr[0]), .prog_ba(prog_ba[0]), .prog_rd(prog_rd[0]), .prog_ack(prog_ack[0]),
    .prog_rdy(prog_rdy[0]), .sdram_dout(sdram_dout[0]));

  jtframe_ram_upload #(.SDRAMW(23), .UPBASE(BASE_B), .UPBA(2'd1), .UPSIZE(SIZE_B), .SWAB(1'b1)) u_b (
    .clk_rom(clk), .rst(rst), .ioctl_ram(ioctl_ram[1]), .ioctl_addr(ioctl_addr[1]),
    .ioctl_rd(ioctl_rd[1]), .ioctl_data2sd(data2sd[1]), .up_busy(up_busy[1]), .up_ovr(up_ovr[1]),
    .prog_addr(prog_addr[1]), .prog_ba(prog_ba[1]), .prog_rd(prog_rd[1]), .prog_ack(prog_ack[1]),
    .prog_rdy(prog_rdy[1]), .sdram_dout(sdram_dout[1]));

  // SDRAM contents, relative to each instance's base
  logic [15:0] mem [64];

  int checks = 0;
  int passed = 0;

  // Responder state
  int          phase[2], cnt[2], ack_dly[2], rdy_dly[2], nreq[2];
  bit          rand_dly[2], first[2];
  logic [22:0] req_l[2];
  logic [22:0] reqs[2][64];
  int          hold_err, hold_samples, ack_err;

  // Reference: byte k of the upload stream
  function automatic logic [7:0] exp_byte(input int i, input int k);
    logic [15:0] w;
    logic [31:0] sz;
    logic        sw;
    sz = (i == 0) ? SIZE_A : SIZE_B;
    sw = (i == 1);
    if (32'(k) >= sz) return 8'hFF;
    w = mem[k / 2];
    return (((k % 2) == 1) ^ sw) ? w[15:8] : w[7:0];
  endfunction

  // SDRAM controller model: ack after a delay, then data after a further delay
  initial begin
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0; cnt[i] = 0; nreq[i] = 0; prog_ack[i] = 1'b0; prog_rdy[i] = 1'b0;
      sdram_dout[i] = '0; first[i] = 1'b0; req_l[i] = '0;
    end
    hold_err = 0; hold_samples = 0; ack_err = 0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        logic [22:0] rel;
        prog_ack[i]   = 1'b0;
        prog_rdy[i]   = 1'b0;
        sdram_dout[i] = 16'($urandom);
        if (rst) phase[i] = 0;
        else case (phase[i])
          0: if (prog_rd[i]) begin
               if (nreq[i] < 64) reqs[i][nreq[i]] = prog_addr[i];
               nreq[i]++;
               req_l[i] = prog_addr[i];
               cnt[i]   = rand_dly[i] ? int'($urandom_range(0, 3)) : ack_dly[i];
               phase[i] = 1;
               if (cnt[i] == 0) begin
                 prog_ack[i] = 1'b1; phase[i] = 2; first[i] = 1'b1;
                 cnt[i] = rand_dly[i] ? int'($urandom_range(0, 3)) : rdy_dly[i];
               end
             end
          1: begin
               hold_samples++;
               if (!prog_rd[i] || prog_addr[i] !== req_l[i]) hold_err++;
               cnt[i]--;
               if (cnt[i] <= 0) begin
                 prog_ack[i] = 1'b1; phase[i] = 2; first[i] = 1'b1;
                 cnt[i] = rand_dly[i] ? int'($urandom_range(0, 3)) : rdy_dly[i];
               end
             end
          default: begin
               if (first[i] && prog_rd[i]) ack_err++;
               first[i] = 1'b0;
               if (cnt[i] <= 0) begin
                 rel = req_l[i] - ((i == 0) ? BASE_A : BASE_B);
                 sdram_dout[i] = mem[rel[5:0]];
                 prog_rdy[i]   = 1'b1;
                 phase[i]      = 0;
               end else cnt[i]--;
             end
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rd(input int i);
    ioctl_rd[i] = 1'b1; tick(1); ioctl_rd[i] = 1'b0;
  endtask

  task automatic end_session(input int i);
    int n;
    ioctl_ram[i] = 1'b0; ioctl_rd[i] = 1'b0; ioctl_addr[i] = '0;
    n = 0;
    while ((phase[i] != 0 || prog_rd[i]) && n < 200) begin tick(1); n++; end
    tick(4);
  endtask

  task automatic start_session(input int i);
    nreq[i] = 0; ioctl_addr[i] = '0; ioctl_ram[i] = 1'b1; tick(1);
  endtask

  task automatic read_byte(input int i, input int k, output logic [7:0] b, output bit to);
    int n;
    ioctl_addr[i] = 25'(k);
    tick(2);
    n = 0;
    while (up_busy[i] && n < 400) begin tick(1); n++; end
    to = up_busy[i];
    tick(1);
    b = data2sd[i];
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      checks++; if (data2sd[i] !== 8'hFF) $display("FAIL reset_data%0d got %h want ff", i, data2sd[i]); else passed++;
      checks++; if (prog_rd[i] !== 1'b0 || up_busy[i] !== 1'b0 || up_ovr[i] !== 1'b0)
        $display("FAIL reset_flags%0d got rd=%b busy=%b ovr=%b want 000", i, prog_rd[i], up_busy[i], up_ovr[i]);
      else passed++;
      checks++; if (prog_addr[i] !== 23'd0 || prog_ba[i] !== 2'd0)
        $display("FAIL reset_addr%0d got %h/%h want 0/0", i, prog_addr[i], prog_ba[i]); else passed++;
    end
  endtask

  task automatic test_basic();
    logic [7:0] b; bit to;
    end_session(0);
    ack_dly[0] = 0; rdy_dly[0] = 0; rand_dly[0] = 1'b0;
    start_session(0);
    tick(20);
    checks++; if (nreq[0] !== 2) $display("FAIL basic_nreq got %0d want 2", nreq[0]); else passed++;
    checks++; if (reqs[0][0] !== BASE_A || reqs[0][1] !== BASE_A + 23'd1)
      $display("FAIL basic_addr got %h,%h want %h,%h", reqs[0][0], reqs[0][1], BASE_A, BASE_A + 23'd1);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      read_byte(0, k, b, to);
      checks++; if (to || b !== exp_byte(0, k))
        $display("FAIL basic_byte%0d got %h timeout=%b want %h", k, b, to, exp_byte(0, k)); else passed++;
      pulse_rd(0);
    end
  endtask

  task automatic test_region_end();
    logic [7:0] b; bit to;
    end_session(1);
    ack_dly[1] = 0; rdy_dly[1] = 0; rand_dly[1] = 1'b0;
    start_session(1);
    for (int k = 0; k < 6; k++) begin
      read_byte(1, k, b, to);
      checks++; if (to || b !== exp_byte(1, k))
        $display("FAIL end_byte%0d got %h timeout=%b want %h", k, b, to, exp_byte(1, k)); else passed++;
      pulse_rd(1);
    end
    tick(10);
    checks++; if (nreq[1] !== 2) $display("FAIL end_nreq got %0d want 2", nreq[1]); else passed++;
    checks++; if (reqs[1][0] !== BASE_B || reqs[1][1] !== 23'd0)
      $display("FAIL end_wrap got %h,%h want %h,0", reqs[1][0], reqs[1][1], BASE_B); else passed++;
    checks++; if (up_ovr[1] !== 1'b0) $display("FAIL end_ovr got %b want 0", up_ovr[1]); else passed++;
    checks++; if (prog_ba[1] !== 2'd1) $display("FAIL end_ba got %h want 1", prog_ba[1]); else passed++;
  endtask

  task automatic test_ack_hold();
    end_session(0);
    ack_dly[0] = 10; rdy_dly[0] = 0;
    hold_err = 0; hold_samples = 0; ack_err = 0;
    start_session(0);
    tick(40);
    checks++; if (hold_samples !== 20) $display("FAIL hold_samples got %0d want 20", hold_samples); else passed++;
    checks++; if (hold_err !== 0) $display("FAIL hold_stable got %0d errors want 0", hold_err); else passed++;
    checks++; if (ack_err !== 0) $display("FAIL ack_drop got %0d errors want 0", ack_err); else passed++;
  endtask

  task automatic test_overrun();
    logic [7:0] b; bit to;
    end_session(0);
    ack_dly[0] = 0; rdy_dly[0] = 20;
    start_session(0);
    read_byte(0, 0, b, to);
    checks++; if (to || b !== exp_byte(0, 0)) $display("FAIL ovr_byte0 got %h want %h", b, exp_byte(0, 0)); else passed++;
    ioctl_addr[0] = 25'd1;
    pulse_rd(0);
    checks++; if (up_busy[0] !== 1'b1) $display("FAIL ovr_busy got %b want 1", up_busy[0]); else passed++;
    checks++; if (up_ovr[0] !== 1'b0) $display("FAIL ovr_early got %b want 0", up_ovr[0]); else passed++;
    ioctl_addr[0] = 25'd2;
    pulse_rd(0);
    checks++; if (up_ovr[0] !== 1'b1) $display("FAIL ovr_set got %b want 1", up_ovr[0]); else passed++;
    for (int k = 2; k < 4; k++) begin
      read_byte(0, k, b, to);
      checks++; if (to || b !== exp_byte(0, k))
        $display("FAIL ovr_byte%0d got %h timeout=%b want %h", k, b, to, exp_byte(0, k)); else passed++;
    end
    checks++; if (up_ovr[0] !== 1'b1) $display("FAIL ovr_sticky got %b want 1", up_ovr[0]); else passed++;
    end_session(0);
    start_session(0);
    tick(1);
    checks++; if (up_ovr[0] !== 1'b0) $display("FAIL ovr_clear got %b want 0", up_ovr[0]); else passed++;
  endtask

  task automatic test_drop_req();
    logic [7:0] b; bit to; int n;
    end_session(0);
    ack_dly[0] = 8; rdy_dly[0] = 3;
    start_session(0);
    n = 0;
    while (!prog_rd[0] && n < 20) begin tick(1); n++; end
    checks++; if (prog_rd[0] !== 1'b1) $display("FAIL drop_req got prog_rd=%b want 1", prog_rd[0]); else passed++;
    ioctl_ram[0] = 1'b0;
    tick(3);
    checks++; if (prog_rd[0] !== 1'b1) $display("FAIL drop_hold got prog_rd=%b want 1", prog_rd[0]); else passed++;
    n = 0;
    while (phase[0] != 0 && n < 50) begin tick(1); n++; end
    tick(15);
    checks++; if (nreq[0] !== 1 || prog_rd[0] !== 1'b0)
      $display("FAIL drop_norequest got nreq=%0d rd=%b want 1/0", nreq[0], prog_rd[0]); else passed++;
    checks++; if (data2sd[0] !== 8'hFF || up_busy[0] !== 1'b0)
      $display("FAIL drop_idle got data=%h busy=%b want ff/0", data2sd[0], up_busy[0]); else passed++;
    ack_dly[0] = 0; rdy_dly[0] = 0;
    start_session(0);
    for (int k = 0; k < 4; k++) begin
      read_byte(0, k, b, to);
      checks++; if (to || b !== exp_byte(0, k))
        $display("FAIL drop_byte%0d got %h timeout=%b want %h", k, b, to, exp_byte(0, k)); else passed++;
      pulse_rd(0);
    end
    checks++; if (reqs[0][0] !== BASE_A) $display("FAIL drop_restart got %h want %h", reqs[0][0], BASE_A); else passed++;
  endtask

  task automatic test_reset_wait();
    logic [7:0] b; bit to; int n;
    end_session(0);
    ack_dly[0] = 0; rdy_dly[0] = 6;
    start_session(0);
    read_byte(0, 0, b, to);
    ioctl_addr[0] = 25'd1; pulse_rd(0);
    ioctl_addr[0] = 25'd2; pulse_rd(0);
    checks++; if (up_ovr[0] !== 1'b1) $display("FAIL rstw_preovr got %b want 1", up_ovr[0]); else passed++;
    n = 0;
    while (!(phase[0] == 2 && cnt[0] >= 2) && n < 40) begin tick(1); n++; end
    checks++; if (phase[0] != 2) $display("FAIL rstw_wait got phase=%0d want 2", phase[0]); else passed++;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (prog_rd[0] !== 1'b0 || up_ovr[0] !== 1'b0 || data2sd[0] !== 8'hFF)
      $display("FAIL rstw_async got rd=%b ovr=%b data=%h want 0/0/ff", prog_rd[0], up_ovr[0], data2sd[0]);
    else passed++;
    ioctl_ram[0] = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(20);
    ack_dly[0] = 0; rdy_dly[0] = 0;
    start_session(0);
    for (int k = 0; k < 4; k++) begin
      read_byte(0, k, b, to);
      checks++; if (to || b !== exp_byte(0, k))
        $display("FAIL rstw_byte%0d got %h timeout=%b want %h", k, b, to, exp_byte(0, k)); else passed++;
      pulse_rd(0);
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] b; bit to; int bad;
    end_session(0);
    rand_dly[0] = 1'b1;
    start_session(0);
    for (int k = 0; k < 68; k++) begin
      tick(int'($urandom_range(0, 3)));
      read_byte(0, k, b, to);
      checks++; if (to || b !== exp_byte(0, k))
        $display("FAIL rand_byte%0d got %h timeout=%b want %h", k, b, to, exp_byte(0, k)); else passed++;
      pulse_rd(0);
    end
    tick(10);
    checks++; if (nreq[0] !== 32) $display("FAIL rand_nreq got %0d want 32", nreq[0]); else passed++;
    bad = 0;
    for (int j = 0; j < 32; j++) if (reqs[0][j] !== BASE_A + 23'(j)) bad++;
    checks++; if (bad != 0) $display("FAIL rand_order got %0d out-of-order requests want 0", bad); else passed++;
    checks++; if (up_ovr[0] !== 1'b0) $display("FAIL rand_ovr got %b want 0", up_ovr[0]); else passed++;
    rand_dly[0] = 1'b0;
  endtask

  initial begin
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    for (int j = 2; j < 64; j++) mem[j] = 16'($urandom);
    for (int i = 0; i < 2; i++) begin
      ioctl_ram[i] = 1'b0; ioctl_rd[i] = 1'b0; ioctl_addr[i] = '0;
      ack_dly[i] = 0; rdy_dly[i] = 0; rand_dly[i] = 1'b0;
    end
    rst = 1'b1;
    tick(3);
    test_reset();
    rst = 1'b0;
    tick(2);
    test_basic();
    test_region_end();
    test_ack_hold();
    test_overrun();
    test_drop_req();
    test_reset_wait();
    test_random_stream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
